// File: rtl/aes_inv_key_sched.sv
// rtl/aes_inv_key_sched.sv - AES-128 inverse key schedule, round 10 down to round 0
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         out_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0x00 sits in the top byte of the table, so the low bit of entry b is 8*(255-b).
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t       state, state_nx;
  logic         accept;
  logic         load, step, fin;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot, sub;
  logic [127:0] key_prev;

  assign accept = key_valid & out_ready;

  // Undo one forward expansion step: recover round r-1 words from round r words.
  assign w0 = key_out[127:96];
  assign w1 = key_out[95:64];
  assign w2 = key_out[63:32];
  assign w3 = key_out[31:0];
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign p0 = w0 ^ sub ^ {rcon(round), 24'h0};
  assign key_prev = {p0, p1, p2, p3};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state plus the load/step/finish strobes that drive the datapath.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (round == 4'd0) begin
            fin      = 1'b1;
            state_nx = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Key register, round counter and handshake flags; key/round persist after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out   <= '0;
      round     <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        key_out   <= key_in;
        round     <= 4'd10;
        key_valid <= 1'b1;
        busy      <= 1'b1;
      end else if (step) begin
        key_out <= key_prev;
        round   <= round - 4'd1;
      end else if (fin) begin
        key_valid <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb/tb_aes_inv_key_sched.sv - scoreboard bench for aes_inv_key_sched
module tb_aes_inv_key_sched;

  localparam logic [127:0] RK0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         ck;
  } exp_t;

  logic         clk = 1'b1;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         out_ready;
  logic [127:0] key_out;
  logic [3:0]   round;
  logic         key_valid;
  logic         busy;
  logic         done;

  int           n_assert = 0;
  int           n_fail = 0;
  int           done_cnt = 0;
  int           d0;
  logic [127:0] rk [0:10];
  logic [3:0]   pat = 4'b1001;
  exp_t         sb [$];

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .out_ready (out_ready),
    .key_out   (key_out),
    .round     (round),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] sb8(input logic [7:0] b);
    sb8 = SB[2047 - 8*int'(b) -: 8];
  endfunction

  // Forward FIPS-197 expansion from the cipher key gives every round key.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb8(t[31:24]), sb8(t[23:16]), sb8(t[15:8]), sb8(t[7:0])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk_k(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_fips();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = rk[r];
      e.ck  = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic push_zero();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = '0;
      e.ck  = (r == 10);
      sb.push_back(e);
    end
  endtask

  // One clock: observe on the falling edge, return 1 time unit after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (done) done_cnt++;
    if (key_valid && out_ready) begin
      chk_v("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_v("acc_round", 32'(round), 32'(e.rnd));
        if (e.ck) chk_k("acc_key", key_out, e.key);
      end
    end else if (key_valid && sb.size() != 0) begin
      chk_v("hold_round", 32'(round), 32'(sb[0].rnd));
      if (sb[0].ck) chk_k("hold_key", key_out, sb[0].key);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b1; key_in = '0;
    expand(RK0);
    #1 rst_n = 1'b0;
    #1;
    chk_k("rst_key", key_out, '0);
    chk_v("rst_round", 32'(round), 32'd0);
    chk_v("rst_valid", 32'(key_valid), 32'd0);
    chk_v("rst_busy", 32'(busy), 32'd0);
    chk_v("rst_done", 32'(done), 32'd0);

    // FIPS vector, out_ready high, with a stray start pulse in RUN.
    #1 rst_n = 1'b1; start = 1'b1; key_in = rk[10];
    push_fips();
    cycle();
    chk_v("start_valid", 32'(key_valid), 32'd1);
    chk_v("start_busy", 32'(busy), 32'd1);
    chk_v("start_round", 32'(round), 32'd10);
    chk_k("start_key", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom}; end
      if (i == 5) begin start = 1'b0; key_in = rk[10]; end
      cycle();
    end
    chk_v("r0_round", 32'(round), 32'd0);
    chk_k("r0_key", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk_v("r0_done_low", 32'(done), 32'd0);
    cycle();
    chk_v("done_at_12", 32'(done), 32'd1);
    chk_v("done_valid", 32'(key_valid), 32'd0);
    chk_v("done_busy", 32'(busy), 32'd0);
    chk_k("done_key", key_out, RK0);
    chk_v("sb_empty_1", 32'(sb.size()), 32'd0);

    // Restart with an all-zero key in the cycle done is high.
    push_zero();
    start = 1'b1; key_in = '0;
    cycle();
    start = 1'b0;
    chk_v("z_round", 32'(round), 32'd10);
    chk_k("z_key", key_out, '0);
    chk_v("z_valid", 32'(key_valid), 32'd1);
    chk_v("z_done_pulse", 32'(done), 32'd0);
    repeat (11) cycle();
    chk_v("z_done", 32'(done), 32'd1);
    chk_v("sb_empty_2", 32'(sb.size()), 32'd0);

    // Backpressure pattern 1,0,0,1.
    push_fips();
    start = 1'b1; key_in = rk[10];
    cycle();
    start = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 100 && done_cnt == d0; i++) begin
      out_ready = pat[3 - (i % 4)];
      cycle();
    end
    out_ready = 1'b1;
    chk_v("bp_done", 32'(done_cnt), 32'(d0 + 1));
    chk_v("sb_empty_3", 32'(sb.size()), 32'd0);
    repeat (2) cycle();
    chk_k("idle_hold_key", key_out, RK0);
    chk_v("idle_hold_round", 32'(round), 32'd0);
    chk_v("idle_valid", 32'(key_valid), 32'd0);

    // Reset at round 5 abandons the schedule.
    push_fips();
    start = 1'b1; key_in = rk[10];
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    chk_v("mid_round", 32'(round), 32'd5);
    chk_k("mid_key", key_out, rk[5]);
    #2 rst_n = 1'b0;
    #1;
    chk_k("mrst_key", key_out, '0);
    chk_v("mrst_round", 32'(round), 32'd0);
    chk_v("mrst_valid", 32'(key_valid), 32'd0);
    chk_v("mrst_busy", 32'(busy), 32'd0);
    chk_v("mrst_done", 32'(done), 32'd0);
    sb.delete();
    d0 = done_cnt;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk_v("no_done_after_rst", 32'(done_cnt), 32'(d0));
    chk_v("idle_after_rst", 32'(key_valid), 32'd0);

    push_fips();
    start = 1'b1; key_in = rk[10];
    cycle();
    start = 1'b0;
    for (int i = 0; i < 40 && done_cnt == d0; i++) cycle();
    chk_v("post_rst_done", 32'(done_cnt), 32'(d0 + 1));
    chk_v("sb_empty_4", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
